// File: rtl/battery_sprite_ctrl.sv
// Battery pickup sprite controller: spawn/lifetime FSM, tear-free position commit,
// screen-space hit test, ROM addressing and 2-stage palette pipeline. Blink phase: BATTERY_BLINK_EN.
module battery_sprite_ctrl #(
  parameter int         SPR_W           = 32,
  parameter int         SPR_H           = 32,
  parameter int         ADDR_W          = 10,
  parameter int         LIFE_FRAMES     = 600,
  parameter int         BLINK_FRAMES    = 120,
  parameter logic [3:0] TRANSPARENT_IDX = 4'd0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              spawn,
  input  logic [9:0]        spawn_x,
  input  logic [9:0]        spawn_y,
  input  logic              collect,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pal_index,
  input  logic [3:0]        pal_r,
  input  logic [3:0]        pal_g,
  input  logic [3:0]        pal_b,
  output logic              pix_valid,
  output logic [3:0]        pix_r,
  output logic [3:0]        pix_g,
  output logic [3:0]        pix_b,
  output logic              active,
  output logic              collected
);

  localparam int XB = $clog2(SPR_W);
  localparam int YB = $clog2(SPR_H);
  localparam int LW = $clog2(LIFE_FRAMES);

`ifdef BATTERY_BLINK_EN
  localparam int BLINK_LEN = BLINK_FRAMES;
  localparam logic [LW-1:0] LIFE_LAST = LW'(LIFE_FRAMES - 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_BLINK = 2'd2} state_t;
`else
  // Without blinking the whole lifetime is spent in ACTIVE.
  localparam int BLINK_LEN = 0 * BLINK_FRAMES;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1} state_t;
`endif
  localparam logic [LW-1:0] ACT_LAST = LW'(LIFE_FRAMES - BLINK_LEN - 1);

  state_t            r_state, w_state_nxt;
  logic [LW-1:0]     r_life, w_life_nxt;
  logic [9:0]        r_pend_x, r_pend_y, r_pos_x, r_pos_y;
  logic [9:0]        w_commit_x, w_commit_y;
  logic              r_vis, w_vis_nxt, w_collected_nxt;
  logic              r_hit1, r_pix_valid, r_active, r_collected, w_pix_valid_nxt;
  logic [3:0]        r_pix_r, r_pix_g, r_pix_b;
  logic [10:0]       w_x_end, w_y_end;
  logic              w_hit0;
  logic [XB-1:0]     w_dx;
  logic [YB-1:0]     w_dy;

  // Next-state, lifetime counter and collect acceptance; spawn overrides every other event
  always_comb begin
    w_state_nxt     = r_state;
    w_life_nxt      = r_life;
    w_collected_nxt = 1'b0;
    if (spawn) begin
      w_state_nxt = S_ACTIVE;
      w_life_nxt  = {LW{1'b0}};
    end else if (collect && (r_state != S_IDLE)) begin
      w_state_nxt     = S_IDLE;
      w_collected_nxt = 1'b1;
    end else if (frame_start) begin
      case (r_state)
        S_ACTIVE: begin
          w_life_nxt = r_life + {{(LW-1){1'b0}}, 1'b1};
`ifdef BATTERY_BLINK_EN
          w_state_nxt = (r_life == ACT_LAST) ? S_BLINK : S_ACTIVE;
`else
          w_state_nxt = (r_life == ACT_LAST) ? S_IDLE : S_ACTIVE;
`endif
        end
`ifdef BATTERY_BLINK_EN
        S_BLINK: begin
          w_life_nxt  = r_life + {{(LW-1){1'b0}}, 1'b1};
          w_state_nxt = (r_life == LIFE_LAST) ? S_IDLE : S_BLINK;
        end
`endif
        default: w_state_nxt = r_state;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Visibility committed at frame start reflects the state entered on that edge
  always_comb begin
    w_vis_nxt = 1'b0;
`ifdef BATTERY_BLINK_EN
    if (w_state_nxt == S_ACTIVE) begin
      w_vis_nxt = 1'b1;
    end else if (w_state_nxt == S_BLINK) begin
      w_vis_nxt = ~w_life_nxt[2];
    end else begin
      w_vis_nxt = 1'b0;
    end
`else
    w_vis_nxt = (w_state_nxt == S_ACTIVE);
`endif
  end

  assign w_commit_x = spawn ? spawn_x : r_pend_x;
  assign w_commit_y = spawn ? spawn_y : r_pend_y;

  // Hit test against committed position; 11-bit bounds keep sprites near the edge from wrapping
  assign w_x_end   = {1'b0, r_pos_x} + 11'(SPR_W);
  assign w_y_end   = {1'b0, r_pos_y} + 11'(SPR_H);
  assign w_hit0    = (draw_x >= r_pos_x) && ({1'b0, draw_x} < w_x_end) &&
                     (draw_y >= r_pos_y) && ({1'b0, draw_y} < w_y_end);
  assign w_dx      = draw_x[XB-1:0] - r_pos_x[XB-1:0];
  assign w_dy      = draw_y[YB-1:0] - r_pos_y[YB-1:0];
  assign rom_addr  = w_hit0 ? ADDR_W'({w_dy, w_dx}) : {ADDR_W{1'b0}};
  assign pal_index = rom_data;

  assign w_pix_valid_nxt = r_hit1 && (rom_data != TRANSPARENT_IDX);

  // FSM state, lifetime counter and pending spawn position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_life   <= {LW{1'b0}};
      r_pend_x <= 10'd0;
      r_pend_y <= 10'd0;
    end else begin
      r_state <= w_state_nxt;
      r_life  <= w_life_nxt;
      if (spawn) begin
        r_pend_x <= spawn_x;
        r_pend_y <= spawn_y;
      end
    end
  end

  // Shadow commit of position and visibility, only at frame start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pos_x <= 10'd0;
      r_pos_y <= 10'd0;
      r_vis   <= 1'b0;
    end else if (frame_start) begin
      r_pos_x <= w_commit_x;
      r_pos_y <= w_commit_y;
      r_vis   <= w_vis_nxt;
    end
  end

  // Pixel pipeline (hit aligned with ROM data, then colour) and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit1      <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_r     <= 4'd0;
      r_pix_g     <= 4'd0;
      r_pix_b     <= 4'd0;
      r_active    <= 1'b0;
      r_collected <= 1'b0;
    end else begin
      r_hit1      <= w_hit0 & r_vis;
      r_pix_valid <= w_pix_valid_nxt;
      r_pix_r     <= w_pix_valid_nxt ? pal_r : 4'd0;
      r_pix_g     <= w_pix_valid_nxt ? pal_g : 4'd0;
      r_pix_b     <= w_pix_valid_nxt ? pal_b : 4'd0;
      r_active    <= (w_state_nxt != S_IDLE);
      r_collected <= w_collected_nxt;
    end
  end

  assign pix_valid = r_pix_valid;
  assign pix_r     = r_pix_r;
  assign pix_g     = r_pix_g;
  assign pix_b     = r_pix_b;
  assign active    = r_active;
  assign collected = r_collected;

endmodule
